control_alarma: RTL and testbench

//   Mode/alarm controller for the BCD clock datapath. Debounces the four push buttons and runs a mode FSM (RUN / AJ_RELOJ / AJ_ALARMA).

---
 rtl/reloj_pkg.sv | 26 ++
 rtl/control_alarma_antirrebote.sv | 40 ++++
 rtl/control_alarma.sv | 108 ++++++++++
 tb/tb_control_alarma.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/reloj_pkg.sv
// Shared encodings and BCD helpers for the clock mode/alarm controller.
package reloj_pkg;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    AJ_RELOJ  = 2'd1,
    AJ_ALARMA = 2'd2
  } estado_t;

  localparam logic [7:0] MIN_MAX = 8'h59;
  localparam logic [7:0] HOR_MAX = 8'h23;

  localparam int NUM_BTN = 4;
  localparam int B_MODO  = 0;
  localparam int B_MIN   = 1;
  localparam int B_HOR   = 2;
  localparam int B_ALARM = 3;

  // Two-digit BCD +1 that wraps to 00 once the top value is reached.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] tope);
    if (v == tope)          return 8'h00;
    else if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'h0};
    else                    return {v[7:4], v[3:0] + 4'd1};
  endfunction

endpackage

// File: rtl/control_alarma_antirrebote.sv
// Button conditioner: 2-FF synchroniser, stability counter, and a one-cycle
// pulse on each accepted rising level.
module antirrebote #(
  parameter int DEB_CICLOS = 500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulso
);
  localparam int CW = $clog2(DEB_CICLOS + 1);

  logic          s1, s2, s3, acept;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      s3    <= 1'b0;
      acept <= 1'b0;
      cnt   <= '0;
      pulso <= 1'b0;
    end else begin
      s1    <= btn;
      s2    <= s1;
      s3    <= s2;
      pulso <= 1'b0;
      // s3 is the previous sample; any change restarts the stability window
      if (s2 != s3)
        cnt <= '0;
      else if (cnt != CW'(DEB_CICLOS - 1))
        cnt <= cnt + 1'b1;
      else if (s3 != acept) begin
        acept <= s3;
        pulso <= s3;
      end
    end
  end
endmodule

// File: rtl/control_alarma.sv
// Mode FSM, alarm time registers and buzzer control for the BCD clock.
module control_alarma
  import reloj_pkg::*;
#(
  parameter int DEB_CICLOS      = 500_000,
  parameter int DURACION_ALARMA = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_modo,
  input  logic        btn_min,
  input  logic        btn_hor,
  input  logic        btn_alarma,
  input  logic        tick_seg,
  input  logic        seg_cero,
  input  logic [15:0] hora_bcd,
  output logic        inc_min,
  output logic        inc_hor,
  output logic        detener,
  output logic        mostrar_alarma,
  output logic [15:0] disp_bcd,
  output logic        alarma_armada,
  output logic        zumbador
);
  localparam int TW = $clog2(DURACION_ALARMA + 1);

  logic [NUM_BTN-1:0] btns, p;
  estado_t            estado, nxt;
  logic [7:0]         al_h, al_m;
  logic               sonando, disparado;
  logic [TW-1:0]      cnt_tick;
  logic               pm, ph, pa, disparar, entra_aj;

  assign btns = {btn_alarma, btn_hor, btn_min, btn_modo};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_deb
    antirrebote #(.DEB_CICLOS(DEB_CICLOS)) u_deb (
      .clk   (clk),
      .rst   (rst),
      .btn   (btns[i]),
      .pulso (p[i])
    );
  end

  // A mode press swallows any other press landing in the same cycle
  assign pm       = p[B_MIN]   & ~p[B_MODO];
  assign ph       = p[B_HOR]   & ~p[B_MODO];
  assign pa       = p[B_ALARM] & ~p[B_MODO];
  assign entra_aj = (estado == RUN) && p[B_MODO];
  assign disparar = (estado == RUN) && alarma_armada && !disparado &&
                    seg_cero && (hora_bcd == {al_h, al_m});

  always_comb begin
    nxt = estado;
    if (p[B_MODO]) begin
      case (estado)
        RUN:      nxt = AJ_RELOJ;
        AJ_RELOJ: nxt = AJ_ALARMA;
        default:  nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado         <= RUN;
      inc_min        <= 1'b0;
      inc_hor        <= 1'b0;
      detener        <= 1'b0;
      mostrar_alarma <= 1'b0;
      al_h           <= 8'h00;
      al_m           <= 8'h00;
      alarma_armada  <= 1'b0;
      sonando        <= 1'b0;
      zumbador       <= 1'b0;
      disparado      <= 1'b0;
      cnt_tick       <= '0;
    end else begin
      estado         <= nxt;
      inc_min        <= (estado == AJ_RELOJ) && pm;
      inc_hor        <= (estado == AJ_RELOJ) && ph;
      detener        <= (nxt == AJ_RELOJ);
      mostrar_alarma <= (nxt == AJ_ALARMA);
      if (estado == AJ_ALARMA && pm) al_m <= bcd_inc(al_m, MIN_MAX);
      if (estado == AJ_ALARMA && ph) al_h <= bcd_inc(al_h, HOR_MAX);
      if (estado == RUN && pa && !sonando) alarma_armada <= ~alarma_armada;
      if (hora_bcd != {al_h, al_m}) disparado <= 1'b0;

      if (sonando) begin
        if (pa || entra_aj || (tick_seg && cnt_tick == TW'(DURACION_ALARMA - 1))) begin
          sonando  <= 1'b0;
          zumbador <= 1'b0;
          cnt_tick <= '0;
        end else if (tick_seg) begin
          cnt_tick <= cnt_tick + 1'b1;
          zumbador <= ~zumbador;
        end
      end else if (disparar) begin
        sonando   <= 1'b1;
        zumbador  <= 1'b1;
        disparado <= 1'b1;
        cnt_tick  <= '0;
      end
    end
  end

  assign disp_bcd = mostrar_alarma ? {al_h, al_m} : hora_bcd;
endmodule

// File: tb/tb_control_alarma.sv
// Scoreboarded directed bench for control_alarma with a short debounce window.
module tb_control_alarma;
  logic        clk = 1'b0, rst = 1'b1;
  logic        btn_modo = 0, btn_min = 0, btn_hor = 0, btn_alarma = 0;
  logic        tick_seg = 0, seg_cero = 0;
  logic [15:0] hora_bcd = 16'h1200;
  logic        inc_min, inc_hor, detener, mostrar_alarma, alarma_armada, zumbador;
  logic [15:0] disp_bcd;

  int checks = 0, errors = 0;
  int q[$];  // expected datapath pulses: 1 = inc_min, 2 = inc_hor

  control_alarma #(.DEB_CICLOS(4), .DURACION_ALARMA(60)) dut (
    .clk(clk), .rst(rst), .btn_modo(btn_modo), .btn_min(btn_min), .btn_hor(btn_hor),
    .btn_alarma(btn_alarma), .tick_seg(tick_seg), .seg_cero(seg_cero), .hora_bcd(hora_bcd),
    .inc_min(inc_min), .inc_hor(inc_hor), .detener(detener), .mostrar_alarma(mostrar_alarma),
    .disp_bcd(disp_bcd), .alarma_armada(alarma_armada), .zumbador(zumbador)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_q(input string nm);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s pending_pulses got %0d want 0", nm, q.size());
      q.delete();
    end
  endtask

  task automatic pop_chk(input int k, input string nm);
    int e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL %s unexpected pulse got 1 want 0", nm);
    end else begin
      e = q.pop_front();
      if (e != k) begin
        errors++;
        $display("FAIL %s pulse kind got %0d want %0d", nm, k, e);
      end
    end
  endtask

  // Monitor: every datapath pulse must match the head of the expectation queue
  always @(negedge clk) begin
    if (!rst) begin
      if (inc_min) pop_chk(1, "inc_min");
      if (inc_hor) pop_chk(2, "inc_hor");
    end
  end

  task automatic press(input logic m, input logic mi, input logic h, input logic a);
    btn_modo = m; btn_min = mi; btn_hor = h; btn_alarma = a;
    step(10);
    btn_modo = 0; btn_min = 0; btn_hor = 0; btn_alarma = 0;
    step(10);
  endtask

  task automatic bounce_min();
    btn_min = 1; step(1);
    btn_min = 0; step(1);
    btn_min = 1; step(1);
    btn_min = 0; step(1);
    btn_min = 1; step(10);
    btn_min = 0; step(12);
  endtask

  task automatic retrigger();
    hora_bcd = 16'h0631; step(2);
    hora_bcd = 16'h0630; step(2);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    step(3);
    chk("rst_zumb", 16'(zumbador), 16'h0);
    chk("rst_det", 16'(detener), 16'h0);
    chk("rst_disp", disp_bcd, 16'h1200);
    rst = 0;
    step(2);

    // 1/2: pulses in RUN are ignored; AJ_RELOJ forwards min/hor
    bounce_min();
    chk_q("run_no_inc");
    press(1, 0, 0, 0);
    chk("aj_det", 16'(detener), 16'h1);
    chk("aj_most", 16'(mostrar_alarma), 16'h0);
    q.push_back(1);
    bounce_min();
    chk_q("bounce_one_inc");
    q.push_back(2);
    press(0, 0, 1, 0);
    chk_q("inc_hor");
    q.push_back(1); q.push_back(2);
    press(0, 1, 1, 0);
    chk_q("inc_both");
    press(1, 1, 0, 0);  // mode wins, min dropped
    chk_q("modo_wins");
    chk("alm_most", 16'(mostrar_alarma), 16'h1);
    chk("alm_det", 16'(detener), 16'h0);
    chk("alm_disp0", disp_bcd, 16'h0000);

    // 3: alarm registers, BCD wrap
    repeat (23) press(0, 0, 1, 0);
    repeat (59) press(0, 1, 0, 0);
    chk("alm_2359", disp_bcd, 16'h2359);
    press(0, 1, 0, 0);
    chk("alm_2300", disp_bcd, 16'h2300);
    press(0, 0, 1, 0);
    chk("alm_0000", disp_bcd, 16'h0000);
    repeat (6) press(0, 0, 1, 0);
    repeat (30) press(0, 1, 0, 0);
    chk("alm_0630", disp_bcd, 16'h0630);
    chk_q("alm_no_inc");
    press(1, 0, 0, 0);
    chk("run_det", 16'(detener), 16'h0);
    chk("run_most", 16'(mostrar_alarma), 16'h0);

    // 4: trigger and 60-tick run
    hora_bcd = 16'h0630;
    step(1);
    chk("disp_live", disp_bcd, 16'h0630);
    press(0, 0, 0, 1);
    chk("armed", 16'(alarma_armada), 16'h1);
    chk("no_trig_seg", 16'(zumbador), 16'h0);
    seg_cero = 1;
    step(2);
    chk("trig", 16'(zumbador), 16'h1);
    for (int i = 1; i <= 60; i++) begin
      tick_seg = 1; step(1);
      tick_seg = 0; step(1);
      chk($sformatf("tick%0d", i), 16'(zumbador), (i < 60) ? 16'(i % 2 == 0) : 16'h0);
    end
    step(5);
    chk("no_retrig", 16'(zumbador), 16'h0);
    chk("armed_after", 16'(alarma_armada), 16'h1);

    // entering AJ_RELOJ silences
    retrigger();
    chk("trig2", 16'(zumbador), 16'h1);
    press(1, 0, 0, 0);
    chk("aj_silence", 16'(zumbador), 16'h0);
    press(1, 0, 0, 0);
    press(1, 0, 0, 0);
    chk("back_run", 16'(detener), 16'h0);
    chk("back_run_z", 16'(zumbador), 16'h0);

    // 5: p_alarma silences while sounding, toggles otherwise
    retrigger();
    chk("trig3", 16'(zumbador), 16'h1);
    press(0, 0, 0, 1);
    chk("silence", 16'(zumbador), 16'h0);
    chk("silence_arm", 16'(alarma_armada), 16'h1);
    press(0, 0, 0, 1);
    chk("disarm", 16'(alarma_armada), 16'h0);
    press(0, 0, 0, 1);
    chk("rearm", 16'(alarma_armada), 16'h1);

    // 6: async reset while sounding
    retrigger();
    chk("trig4", 16'(zumbador), 16'h1);
    @(negedge clk);
    rst = 1;
    #1;
    chk("arst_zumb", 16'(zumbador), 16'h0);
    chk("arst_arm", 16'(alarma_armada), 16'h0);
    chk("arst_out", {12'h0, inc_min, inc_hor, detener, mostrar_alarma}, 16'h0);
    step(2);
    rst = 0;
    step(2);
    press(1, 0, 0, 0);
    press(1, 0, 0, 0);
    chk("arst_alm", disp_bcd, 16'h0000);
    chk_q("final_q");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
